forwarding_scoreboard: RTL and testbench

- Parametrised successor of the EX-stage forwarding logic.
- Holds its own shadow pipeline of DEPTH in-flight register writes behind EX. Entry 0 is youngest (MEM); entry DEPTH-1 is oldest (WB/retire).
- For NUM_SRC source operands it resolves bypass data, selecting the youngest matching write.
- Raises a load-use stall when the matching write's data is not yet available. Also drives the register-file write port from the retiring entry.

---
 rtl/forwarding_scoreboard_if.sv | 39 +++
 rtl/forwarding_scoreboard.sv | 130 +++++++++++++
 tb/tb_forwarding_scoreboard.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/forwarding_scoreboard_if.sv
// Pipeline-side bundle for forwarding_scoreboard: EX insertion, late load data,
// per-source bypass results and the register-file write port.
interface forwarding_scoreboard_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                       hold;
  logic                       flush;
  logic                       ex_valid;
  logic                       ex_reg_write;
  logic [RADDR_W-1:0]         ex_rd_addr;
  logic [XLEN-1:0]            ex_result;
  logic                       ex_result_ready;
  logic                       late_valid;
  logic [XLEN-1:0]            late_data;
  logic [NUM_SRC*RADDR_W-1:0] src_addr;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic [NUM_SRC*XLEN-1:0]    fwd_data;
  logic                       stall;
  logic                       late_wait;
  logic                       wb_en;
  logic [RADDR_W-1:0]         wb_addr;
  logic [XLEN-1:0]            wb_data;

  modport master (
    output hold, flush, ex_valid, ex_reg_write, ex_rd_addr, ex_result, ex_result_ready,
           late_valid, late_data, src_addr,
    input  fwd_sel, fwd_data, stall, late_wait, wb_en, wb_addr, wb_data
  );
  modport slave (
    input  hold, flush, ex_valid, ex_reg_write, ex_rd_addr, ex_result, ex_result_ready,
           late_valid, late_data, src_addr,
    output fwd_sel, fwd_data, stall, late_wait, wb_en, wb_addr, wb_data
  );
endinterface

// File: rtl/forwarding_scoreboard.sv
// Shadow pipeline of in-flight register writes behind EX with youngest-first bypass
// resolution, load-use stall and retire write port. Optional stats: FWD_SCOREBOARD_STATS_EN.
module fwd_resolve #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int DEPTH   = 3,
  parameter int SEL_W   = 2
) (
  input  logic [RADDR_W-1:0]            src,
  input  logic [DEPTH-1:0]              vld,
  input  logic [DEPTH-1:0]              rdy,
  input  logic [DEPTH-1:0][RADDR_W-1:0] rd,
  input  logic [DEPTH-1:0][XLEN-1:0]    data,
  output logic [SEL_W-1:0]              sel,
  output logic [XLEN-1:0]               dat,
  output logic                          stl
);
  logic hit;

  // First match wins, so a younger not-ready write masks any older ready one.
  always_comb begin
    sel = '0;
    dat = '0;
    stl = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && vld[i] && rd[i] == src && src != '0) begin
        hit = 1'b1;
        if (rdy[i]) begin
          sel = SEL_W'(i + 1);
          dat = data[i];
        end else begin
          stl = 1'b1;
        end
      end
    end
  end
endmodule

module forwarding_scoreboard #(
  parameter int XLEN       = 32,
  parameter int RADDR_W    = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LATE_STAGE = 0
) (
  input logic clk,
  input logic rst,
  forwarding_scoreboard_if.slave bus
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [31:0] stat_fwd_cnt,
  output logic [31:0] stat_stall_cnt
`endif
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]              e_vld, e_rdy;
  logic [DEPTH-1:0][RADDR_W-1:0] e_rd;
  logic [DEPTH-1:0][XLEN-1:0]    e_data;

  logic [NUM_SRC-1:0][SEL_W-1:0] sel_v;
  logic [NUM_SRC-1:0][XLEN-1:0]  dat_v;
  logic [NUM_SRC-1:0]            src_stall;
  logic                          cap, adv, ins_vld;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_resolve #(.XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH), .SEL_W(SEL_W)) u_res (
      .src (bus.src_addr[s*RADDR_W +: RADDR_W]),
      .vld (e_vld),
      .rdy (e_rdy),
      .rd  (e_rd),
      .data(e_data),
      .sel (sel_v[s]),
      .dat (dat_v[s]),
      .stl (src_stall[s])
    );
  end

  assign bus.fwd_sel   = sel_v;
  assign bus.fwd_data  = dat_v;
  assign bus.stall     = |src_stall;
  assign cap           = e_vld[LATE_STAGE] && !e_rdy[LATE_STAGE] && bus.late_valid;
  assign bus.late_wait = e_vld[LATE_STAGE] && !e_rdy[LATE_STAGE] && !bus.late_valid;
  assign adv           = !bus.hold && !bus.late_wait;
  assign ins_vld       = bus.ex_valid && bus.ex_reg_write && bus.ex_rd_addr != '0 &&
                         !bus.flush && !bus.stall;

  // Retire port is gated in the reset cycle so nothing squashed reaches the regfile.
  assign bus.wb_en   = e_vld[DEPTH-1] && !bus.hold && !rst;
  assign bus.wb_addr = e_rd[DEPTH-1];
  assign bus.wb_data = e_data[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      e_vld  <= '0;
      e_rdy  <= '0;
      e_rd   <= '0;
      e_data <= '0;
    end else if (adv) begin
      e_vld  <= {e_vld[DEPTH-2:0], ins_vld};
      e_rdy  <= {e_rdy[DEPTH-2:0], bus.ex_result_ready};
      e_rd   <= {e_rd[DEPTH-2:0], bus.ex_rd_addr};
      e_data <= {e_data[DEPTH-2:0], bus.ex_result};
      // Captured load data rides along with the shift.
      if (cap) begin
        e_rdy[LATE_STAGE+1]  <= 1'b1;
        e_data[LATE_STAGE+1] <= bus.late_data;
      end
    end else if (cap) begin
      e_rdy[LATE_STAGE]  <= 1'b1;
      e_data[LATE_STAGE] <= bus.late_data;
    end
  end

  always_ff @(posedge clk)
    if (!rst && e_vld[DEPTH-1]) assert (e_rdy[DEPTH-1]);

`ifdef FWD_SCOREBOARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fwd_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else if (!bus.hold) begin
      if (|sel_v && stat_fwd_cnt != '1)      stat_fwd_cnt   <= stat_fwd_cnt + 32'd1;
      if (bus.stall && stat_stall_cnt != '1) stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a list-of-writes reference model.
module tb_forwarding_scoreboard;
  localparam int XLEN = 32, RADDR_W = 5, NUM_SRC = 2, DEPTH = 3, LS = 0;
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  forwarding_scoreboard_if #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH)) bus ();

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] stat_fwd, stat_stall;
`endif

  forwarding_scoreboard #(.XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH),
                          .LATE_STAGE(LS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    .stat_fwd_cnt(stat_fwd),
    .stat_stall_cnt(stat_stall)
`endif
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: in-flight writes ordered youngest (index 0) to oldest.
  typedef struct {
    bit v;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0] d;
    bit r;
  } ent_t;
  ent_t m [DEPTH];
  logic [31:0] mc_fwd = 0, mc_stall = 0;

  function automatic logic [RADDR_W-1:0] src(input int s);
    return bus.src_addr[s*RADDR_W +: RADDR_W];
  endfunction

  function automatic void resolve(input logic [RADDR_W-1:0] a, output int sel,
                                  output logic [XLEN-1:0] d, output bit stl);
    sel = 0; d = '0; stl = 0;
    if (a == 0) return;
    for (int i = 0; i < DEPTH; i++)
      if (m[i].v && m[i].rd == a) begin
        if (m[i].r) begin sel = i + 1; d = m[i].d; end
        else stl = 1;
        return;
      end
  endfunction

  function automatic bit m_stall();
    int sel; logic [XLEN-1:0] d; bit stl, any;
    any = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      resolve(src(s), sel, d, stl);
      any = any | stl;
    end
    return any;
  endfunction

  function automatic bit m_any_fwd();
    int sel; logic [XLEN-1:0] d; bit stl, any;
    any = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      resolve(src(s), sel, d, stl);
      if (sel != 0) any = 1;
    end
    return any;
  endfunction

  function automatic bit m_lw();
    return m[LS].v && !m[LS].r && !bus.late_valid;
  endfunction

  always @(posedge clk) begin : model_upd
    ent_t nm [DEPTH];
    bit st, lw;
    st = m_stall();
    lw = m_lw();
    nm = m;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) nm[i] = '{0, '0, '0, 0};
      mc_fwd   <= 0;
      mc_stall <= 0;
    end else begin
      if (!bus.hold) begin
        if (m_any_fwd() && mc_fwd != 32'hFFFF_FFFF) mc_fwd <= mc_fwd + 1;
        if (st && mc_stall != 32'hFFFF_FFFF)        mc_stall <= mc_stall + 1;
      end
      if (nm[LS].v && !nm[LS].r && bus.late_valid) begin
        nm[LS].d = bus.late_data;
        nm[LS].r = 1;
      end
      if (!bus.hold && !lw) begin
        for (int i = DEPTH - 1; i > 0; i--) nm[i] = nm[i-1];
        nm[0].v  = bus.ex_valid && bus.ex_reg_write && bus.ex_rd_addr != 0 && !bus.flush && !st;
        nm[0].rd = bus.ex_rd_addr;
        nm[0].d  = bus.ex_result;
        nm[0].r  = bus.ex_result_ready;
      end
    end
    m <= nm;
  end

  always @(negedge clk) begin : compare
    int sel; logic [XLEN-1:0] d; bit stl, wbe;
    for (int s = 0; s < NUM_SRC; s++) begin
      resolve(src(s), sel, d, stl);
      chk($sformatf("fwd_sel%0d", s), bus.fwd_sel[s*SEL_W +: SEL_W], sel);
      chk($sformatf("fwd_data%0d", s), bus.fwd_data[s*XLEN +: XLEN], d);
    end
    chk("stall", bus.stall, m_stall());
    chk("late_wait", bus.late_wait, m_lw());
    wbe = m[DEPTH-1].v && !bus.hold && !rst;
    chk("wb_en", bus.wb_en, wbe);
    if (wbe) begin
      chk("wb_addr", bus.wb_addr, m[DEPTH-1].rd);
      chk("wb_data", bus.wb_data, m[DEPTH-1].d);
    end
`ifdef FWD_SCOREBOARD_STATS_EN
    chk("stat_fwd", stat_fwd, mc_fwd);
    chk("stat_stall", stat_stall, mc_stall);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.hold = 0; bus.flush = 0; bus.ex_valid = 0; bus.ex_reg_write = 0;
    bus.ex_rd_addr = '0; bus.ex_result = '0; bus.ex_result_ready = 0;
    bus.late_valid = 0; bus.late_data = '0; bus.src_addr = '0;
  endtask

  task automatic ex_wr(input logic [RADDR_W-1:0] rd, input logic [XLEN-1:0] v, input bit rdy);
    bus.ex_valid = 1; bus.ex_reg_write = 1; bus.ex_rd_addr = rd;
    bus.ex_result = v; bus.ex_result_ready = rdy;
  endtask

  task automatic set_src(input int s, input logic [RADDR_W-1:0] a);
    bus.src_addr[s*RADDR_W +: RADDR_W] = a;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH) tick();
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    #3;
    chk("rst_wb_en", bus.wb_en, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_late_wait", bus.late_wait, 0);
    chk("rst_fwd_sel", bus.fwd_sel, 0);
    rst = 0;
    tick();

    // ALU back-to-back
    ex_wr(5, 32'h11, 1); tick();
    idle(); set_src(0, 5); #3;
    chk("alu_sel", bus.fwd_sel[0 +: SEL_W], 1);
    chk("alu_data", bus.fwd_data[0 +: XLEN], 32'h11);
    chk("alu_stall", bus.stall, 0);
    tick(); idle(); tick(); #3;
    chk("alu_wb_en", bus.wb_en, 1);
    chk("alu_wb_addr", bus.wb_addr, 5);
    chk("alu_wb_data", bus.wb_data, 32'h11);
    tick(); drain();

    // Youngest priority
    ex_wr(7, 32'hA, 1); tick();
    ex_wr(7, 32'hB, 1); tick();
    idle(); set_src(1, 7); #3;
    chk("young_sel", bus.fwd_sel[SEL_W +: SEL_W], 1);
    chk("young_data", bus.fwd_data[XLEN +: XLEN], 32'hB);
    tick(); drain();

    // Load-use: stall one cycle, consumer x9 bubbled
    ex_wr(3, 32'h5555, 0); tick();
    idle(); set_src(0, 3); ex_wr(9, 32'h99, 1);
    bus.late_valid = 1; bus.late_data = 32'hDEAD; #3;
    chk("lu_stall", bus.stall, 1);
    chk("lu_sel_stall", bus.fwd_sel[0 +: SEL_W], 0);
    tick();
    idle(); set_src(0, 3); set_src(1, 9); #3;
    chk("lu_sel", bus.fwd_sel[0 +: SEL_W], 2);
    chk("lu_data", bus.fwd_data[0 +: XLEN], 32'hDEAD);
    chk("lu_stall_after", bus.stall, 0);
    chk("lu_bubble", bus.fwd_sel[SEL_W +: SEL_W], 0);
    tick(); drain();

    // Late wait: pipeline frozen until load data arrives
    ex_wr(4, 32'h0, 0); tick();
    idle();
    repeat (3) begin
      #3;
      chk("lw_wait", bus.late_wait, 1);
      chk("lw_no_wb", bus.wb_en, 0);
      tick();
    end
    bus.late_valid = 1; bus.late_data = 32'hBEEF; #3;
    chk("lw_release", bus.late_wait, 0);
    tick(); idle(); tick(); #3;
    chk("lw_wb_en", bus.wb_en, 1);
    chk("lw_wb_addr", bus.wb_addr, 4);
    chk("lw_wb_data", bus.wb_data, 32'hBEEF);
    tick(); drain();

    // x0 destination and flushed write never become visible
    ex_wr(0, 32'h77, 1); tick();
    ex_wr(6, 32'h66, 1); bus.flush = 1; tick();
    idle(); set_src(0, 0); set_src(1, 6);
    repeat (3) begin
      #3;
      chk("x0_sel", bus.fwd_sel, 0);
      chk("x0_stall", bus.stall, 0);
      chk("x0_wb_en", bus.wb_en, 0);
      tick();
    end

    // Reset mid-flight
    ex_wr(1, 32'h1, 1); tick();
    ex_wr(2, 32'h2, 1); tick();
    ex_wr(3, 32'h3, 1); tick();
    idle(); rst = 1; #3;
    chk("rstm_wb_en_rst_cycle", bus.wb_en, 0);
    tick();
    rst = 0; set_src(0, 1); set_src(1, 2); #3;
    chk("rstm_wb_en", bus.wb_en, 0);
    chk("rstm_sel", bus.fwd_sel, 0);
    chk("rstm_stall", bus.stall, 0);
`ifdef FWD_SCOREBOARD_STATS_EN
    chk("rstm_stat_fwd", stat_fwd, 0);
    chk("rstm_stat_stall", stat_stall, 0);
`endif
    tick();

    // Randomized traffic over a small register window to provoke hits
    for (int k = 0; k < 3000; k++) begin
      bus.hold            = ($urandom_range(9) == 0);
      bus.flush           = ($urandom_range(9) == 0);
      bus.ex_valid        = ($urandom_range(3) != 0);
      bus.ex_reg_write    = ($urandom_range(4) != 0);
      bus.ex_rd_addr      = RADDR_W'($urandom_range(7));
      bus.ex_result       = $urandom;
      bus.ex_result_ready = ($urandom_range(2) != 0);
      bus.late_valid      = ($urandom_range(1) != 0);
      bus.late_data       = $urandom;
      for (int s = 0; s < NUM_SRC; s++) set_src(s, RADDR_W'($urandom_range(7)));
      rst = ($urandom_range(199) == 0);
      tick();
    end

    rst = 0; idle(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
